mpmc10_req_drain: RTL

Downstream consumer for the per-channel mpmc10 request FIFOs. It watches NCH channel FIFOs, selects one non-empty channel round-robin, pops one mpmc10_fifoe_t entry with a read-latency-1 handshake, and holds it in an output register until the memory-controller state machine accepts it. It absorbs FIFO reset-busy windows and missing data_valid without deadlocking.

---
 rtl/mpmc10_req_drain.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mpmc10_req_drain.sv
// mpmc10_req_drain
//   Drains the per-channel mpmc10 request FIFOs. One non-empty channel is
//   picked round-robin, one entry is popped with a read-latency-1 handshake,
//   and the entry is held in an output register until the memory-controller
//   FSM accepts it. If the FIFO is in reset-busy or data_valid never shows up,
//   a short timeout returns the FSM to IDLE so the drain cannot deadlock.
//
// Ports
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   fifo_empty     per-channel FIFO empty flag
//   fifo_rst_busy  per-channel rd_rst_busy
//   fifo_v         per-channel data_valid (one cycle after rd_fifo)
//   fifo_dout      per-channel FIFO data
//   rd_fifo        per-channel read enable, registered, one-hot or zero
//   req_o          held request entry
//   req_v          req_o valid
//   req_ch         channel that supplied req_o
//   req_rdy        controller accepts req_o when req_v & req_rdy
//   err            one-cycle pulse when a pop times out

package mpmc10_pkg;
   typedef struct packed {
      logic [3:0]  cid;
      logic [7:0]  tid;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } mpmc10_fifoe_t;
endpackage

// state | meaning
// IDLE  | look for an eligible channel, grant it and raise its rd_fifo
// POP   | rd_fifo[sel] is high this cycle; timeout counter is loaded
// WAIT  | wait for fifo_v[sel]; capture on it, or give up on timeout
// HOLD  | req_o/req_ch/req_v held until req_rdy
module mpmc10_req_drain
   import mpmc10_pkg::*;
#(
   parameter int NCH = 8,
   parameter int TMO = 3
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NCH-1:0]          fifo_empty,
   input  logic [NCH-1:0]          fifo_rst_busy,
   input  logic [NCH-1:0]          fifo_v,
   input  mpmc10_fifoe_t [NCH-1:0] fifo_dout,
   output logic [NCH-1:0]          rd_fifo,
   output mpmc10_fifoe_t           req_o,
   output logic                    req_v,
   output logic [2:0]              req_ch,
   input  logic                    req_rdy,
   output logic                    err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_POP,
      ST_WAIT,
      ST_HOLD
   } state_t;

   // The timeout is a down-counter: loaded with TMO-1 in POP, so WAIT lasts
   // at most TMO cycles. err is registered one cycle ahead of the abort, so
   // it is high during the last WAIT cycle; that cycle is committed to the
   // abort and ignores fifo_v. TMO must be 2..4 for the 2-bit counter.
   localparam logic [1:0] CNT_LOAD = 2'(TMO - 1);
   localparam logic [2:0] PTR_RST  = 3'(NCH - 1);

   state_t        state_q, state_d;
   logic [2:0]    sel_q, sel_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [NCH-1:0] rd_fifo_q, rd_fifo_d;
   mpmc10_fifoe_t req_o_q, req_o_d;
   logic [2:0]    req_ch_q, req_ch_d;
   logic          req_v_q, req_v_d;
   logic          err_q, err_d;

   // Zero-padded to 8 so a 3-bit channel index is always in range.
   logic [7:0]    elig8;
   logic [7:0]    fv8;
   logic          found;
   logic [2:0]    win;
   logic [2:0]    idx;

   always_comb begin
      elig8 = '0;
      fv8   = '0;
      elig8[NCH-1:0] = ~fifo_empty & ~fifo_rst_busy;
      fv8[NCH-1:0]   = fifo_v;
   end

   // Round-robin: search ptr+1, ptr+2, ... wrapping mod NCH; first hit wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = 3'((int'(ptr_q) + k) % NCH);
         if (!found && elig8[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      rd_fifo_d = '0;
      req_o_d   = req_o_q;
      req_ch_d  = req_ch_q;
      req_v_d   = req_v_q;
      err_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               sel_d = win;
               ptr_d = win;
               for (int i = 0; i < NCH; i++) begin
                  rd_fifo_d[i] = (win == 3'(i));
               end
               state_d = ST_POP;
            end
         end
         ST_POP: begin
            cnt_d   = CNT_LOAD;
            err_d   = (CNT_LOAD == 2'd0);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = ST_IDLE;
            end else if (fv8[sel_q]) begin
               req_o_d  = fifo_dout[sel_q];
               req_ch_d = sel_q;
               req_v_d  = 1'b1;
               state_d  = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 2'd1;
               err_d = (cnt_q == 2'd1);
            end
         end
         ST_HOLD: begin
            if (req_v_q && req_rdy) begin
               req_v_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         ptr_q     <= PTR_RST;
         cnt_q     <= '0;
         rd_fifo_q <= '0;
         req_o_q   <= '0;
         req_ch_q  <= '0;
         req_v_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         rd_fifo_q <= rd_fifo_d;
         req_o_q   <= req_o_d;
         req_ch_q  <= req_ch_d;
         req_v_q   <= req_v_d;
         err_q     <= err_d;
      end
   end

   assign rd_fifo = rd_fifo_q;
   assign req_o   = req_o_q;
   assign req_ch  = req_ch_q;
   assign req_v   = req_v_q;
   assign err     = err_q;

endmodule
